// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave with per-bit direction, synchronised inputs,
// edge-detect interrupts (write-1-to-clear status) and pin parity.
module ahb_gpio_irq #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [7:0]  DATA_ADDR = 8'h00,
  parameter logic [7:0]  DIR_ADDR  = 8'h04,
  parameter logic [7:0]  IE_ADDR   = 8'h08,
  parameter logic [7:0]  EDGE_ADDR = 8'h0C,
  parameter logic [7:0]  STAT_ADDR = 8'h10,
  parameter logic [7:0]  CTRL_ADDR = 8'h14
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic             HREADY,
  input  logic             HWRITE,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH:0]   GPIOIN,
  output logic [WIDTH:0]   GPIOOUT,
  output logic [WIDTH-1:0] GPIOEN,
  output logic             GPIOINT,
  output logic             PARITYERR
);

  // Parity of a data word, inverted when odd parity is selected.
  function automatic logic parity_f(input logic [WIDTH-1:0] v, input logic odd);
    return (^v) ^ odd;
  endfunction

  logic [7:0]       addr_r;
  logic             write_r;
  logic             valid_r;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] dir_d_r;
  logic [WIDTH-1:0] ie_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH:0]   stat_r;
  logic [1:0]       ctrl_r;
  logic [WIDTH:0]   sync1_r;
  logic [WIDTH:0]   sync_in_r;
  logic [WIDTH:0]   sync_prev_r;

  logic             wr_data_s, wr_dir_s, wr_ie_s, wr_edge_s, wr_stat_s, wr_ctrl_s;
  logic [WIDTH-1:0] det_s;
  logic             par_err_s;
  logic [WIDTH:0]   stat_set_s;
  logic [WIDTH:0]   stat_clr_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  // Address-phase capture; the data phase of a selected transfer follows one cycle later.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r  <= 8'h00;
      write_r <= 1'b0;
      valid_r <= 1'b0;
    end else if (HREADY) begin
      addr_r  <= HADDR[7:0];
      write_r <= HWRITE;
      valid_r <= HSEL & HTRANS[1];
    end
  end

  // Write-strobe decode for the data phase currently in flight.
  always_comb begin
    wr_data_s = 1'b0;
    wr_dir_s  = 1'b0;
    wr_ie_s   = 1'b0;
    wr_edge_s = 1'b0;
    wr_stat_s = 1'b0;
    wr_ctrl_s = 1'b0;
    if (valid_r && write_r) begin
      case (addr_r)
        DATA_ADDR: wr_data_s = 1'b1;
        DIR_ADDR:  wr_dir_s  = 1'b1;
        IE_ADDR:   wr_ie_s   = 1'b1;
        EDGE_ADDR: wr_edge_s = 1'b1;
        STAT_ADDR: wr_stat_s = 1'b1;
        CTRL_ADDR: wr_ctrl_s = 1'b1;
        default:   wr_data_s = 1'b0;
      endcase
    end else begin
      wr_data_s = 1'b0;
    end
  end

  // Software-visible configuration registers, committed at the end of the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dout_r <= {WIDTH{1'b0}};
      dir_r  <= {WIDTH{1'b0}};
      ie_r   <= {WIDTH{1'b0}};
      edge_r <= {WIDTH{1'b0}};
      ctrl_r <= 2'b00;
    end else begin
      if (wr_data_s) dout_r <= HWDATA[WIDTH-1:0];
      if (wr_dir_s)  dir_r  <= HWDATA[WIDTH-1:0];
      if (wr_ie_s)   ie_r   <= HWDATA[WIDTH-1:0];
      if (wr_edge_s) edge_r <= HWDATA[WIDTH-1:0];
      if (wr_ctrl_s) ctrl_r <= HWDATA[1:0];
    end
  end

  // Two-flop synchroniser plus previous-sample and previous-direction history.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_r     <= {(WIDTH+1){1'b0}};
      sync_in_r   <= {(WIDTH+1){1'b0}};
      sync_prev_r <= {(WIDTH+1){1'b0}};
      dir_d_r     <= {WIDTH{1'b0}};
    end else begin
      sync1_r     <= GPIOIN;
      sync_in_r   <= sync1_r;
      sync_prev_r <= sync_in_r;
      dir_d_r     <= dir_r;
    end
  end

  // Edge and parity event detection; a bit that was an output last cycle is masked so
  // turning a pin around never reports a spurious edge.
  always_comb begin
    det_s = ((edge_r & ~sync_in_r[WIDTH-1:0] & sync_prev_r[WIDTH-1:0]) |
             (~edge_r & sync_in_r[WIDTH-1:0] & ~sync_prev_r[WIDTH-1:0])) & ~dir_r & ~dir_d_r;
    par_err_s  = ctrl_r[1] & (parity_f(sync_in_r[WIDTH-1:0], ctrl_r[0]) != sync_in_r[WIDTH]);
    stat_set_s = {par_err_s, det_s};
    if (wr_stat_s) begin
      stat_clr_s = HWDATA[WIDTH:0];
    end else begin
      stat_clr_s = {(WIDTH+1){1'b0}};
    end
  end

  // Sticky status: a new event on the same cycle as a clear keeps the bit set.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stat_r <= {(WIDTH+1){1'b0}};
    end else begin
      stat_r <= (stat_r & ~stat_clr_s) | stat_set_s;
    end
  end

  // Read-data mux driven from the registered address during the data phase.
  always_comb begin
    rdata_s = 32'd0;
    if (valid_r && !write_r) begin
      case (addr_r)
        DATA_ADDR: rdata_s[WIDTH-1:0] = (sync_in_r[WIDTH-1:0] & ~dir_r) | (dout_r & dir_r);
        DIR_ADDR:  rdata_s[WIDTH-1:0] = dir_r;
        IE_ADDR:   rdata_s[WIDTH-1:0] = ie_r;
        EDGE_ADDR: rdata_s[WIDTH-1:0] = edge_r;
        STAT_ADDR: rdata_s[WIDTH:0]   = stat_r;
        CTRL_ADDR: rdata_s[1:0]       = ctrl_r;
        default:   rdata_s            = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRDATA    = rdata_s;
  assign GPIOOUT   = {parity_f(dout_r & dir_r, ctrl_r[0]), dout_r & dir_r};
  assign GPIOEN    = dir_r;
  assign GPIOINT   = (|(stat_r[WIDTH-1:0] & ie_r)) | (stat_r[WIDTH] & ctrl_r[1]);
  assign PARITYERR = stat_r[WIDTH];
  assign unused_s  = ^{HADDR[31:8], HWDATA};

endmodule
